// File: rtl/cam_frame_reader.sv
// Streams one stored camera frame from the capture RAM to a valid/ready sink.
// Define CAM_PIXCNT_EN to add a per-frame popcount of the streamed words.
module cam_frame_reader #(
    parameter int ADDR_W     = 13,
    parameter int NUM_WORDS  = 2400,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              cap_req,
    input  logic              cap_ready,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
`ifdef CAM_PIXCNT_EN
    ,
    output logic [ADDR_W+5:0] pix_count,
    output logic              pix_count_valid
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_READ,
        S_DRAIN,
        S_REL
    } state_t;

    state_t state, state_next;

    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic             fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             inflight;
    logic             inflight_last;
    logic             aborted;

    logic             active;
    logic             flush;
    logic             pop;
    logic             push;
    logic             issue;
    logic             read_entry;
    logic             done_set;
    logic [OCC_W-1:0] occupancy;

    assign active     = (state == S_REQ) || (state == S_READ) || (state == S_DRAIN);
    assign flush      = active && abort;
    assign pop        = m_valid && m_ready;
    assign push       = inflight && !flush;
    assign read_entry = (state == S_REQ) && cap_ready && !abort;
    assign done_set   = (state == S_REL) && !cap_ready && !aborted;

    // Count the word still in the RAM pipeline so a full FIFO can never be overrun,
    // while a same-cycle pop frees a slot for back-to-back streaming.
    assign occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
    assign issue     = (state == S_READ) && !abort && (occupancy < OCC_W'(FIFO_DEPTH));

    assign busy    = (state != S_IDLE);
    assign cap_req = active;
    assign m_valid = (count != '0);
    assign m_data  = m_valid ? fifo_data[rd_ptr] : '0;
    assign m_last  = m_valid && fifo_last[rd_ptr];

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_REQ;
            end
            S_REQ: begin
                if (abort)          state_next = S_REL;
                else if (cap_ready) state_next = S_READ;
            end
            S_READ: begin
                if (abort)                                state_next = S_REL;
                else if (issue && ram_raddr == LAST_ADDR) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)                           state_next = S_REL;
                else if (!inflight && count == '0)   state_next = S_REL;
            end
            S_REL: begin
                if (!cap_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state         <= S_IDLE;
            ram_raddr     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            aborted       <= 1'b0;
            done          <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_set;

            if (state == S_IDLE && start) aborted <= 1'b0;
            else if (flush)               aborted <= 1'b1;

            if (read_entry)                             ram_raddr <= '0;
            else if (issue && ram_raddr != LAST_ADDR)   ram_raddr <= ram_raddr + ADDR_W'(1);

            // issue is already blocked by abort, so a flush also empties the RAM pipeline
            inflight      <= issue;
            inflight_last <= issue && (ram_raddr == LAST_ADDR);

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) begin
            fifo_data[wr_ptr] <= ram_rdata;
            fifo_last[wr_ptr] <= inflight_last;
        end
    end

`ifdef CAM_PIXCNT_EN
    localparam int PIX_W = ADDR_W + 6;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pix_count       <= '0;
            pix_count_valid <= 1'b0;
        end else begin
            if (read_entry) pix_count <= '0;
            else if (pop)   pix_count <= pix_count + PIX_W'($countones(m_data));

            if (state == S_IDLE && start) pix_count_valid <= 1'b0;
            else if (done_set)            pix_count_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cam_frame_reader.sv
// Self-checking bench for cam_frame_reader: an 8-word instance and a 1-word instance share stimulus.
// Expected streams come from a behavioural RAM image; CAM_PIXCNT_EN enables the popcount test.
module tb_cam_frame_reader;

    localparam int ADDR_W = 13;

    logic HCLK = 1'b0;
    logic HRESET = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic cap_ready = 1'b0;
    logic m_ready = 1'b1;

    logic              a_busy, a_done, a_cap_req, a_valid, a_last;
    logic [ADDR_W-1:0] a_raddr;
    logic [31:0]       a_rdata, a_data;
    logic              b_busy, b_done, b_cap_req, b_valid, b_last;
    logic [ADDR_W-1:0] b_raddr;
    logic [31:0]       b_rdata, b_data;
`ifdef CAM_PIXCNT_EN
    logic [ADDR_W+5:0] a_pix, b_pix;
    logic              a_pixv, b_pixv;
`endif

    logic [31:0] mem [0:7];

    int n_checks = 0;
    int n_fails = 0;

    logic sel = 1'b0;
    int   ready_mode = 0;
    logic stall_req = 1'b0;
    logic mon_clear = 1'b0;

    always #5 HCLK = ~HCLK;

    cam_frame_reader #(.ADDR_W(ADDR_W), .NUM_WORDS(8), .FIFO_DEPTH(4)) dut_a (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .abort(abort),
        .busy(a_busy), .done(a_done), .cap_req(a_cap_req), .cap_ready(cap_ready),
        .ram_raddr(a_raddr), .ram_rdata(a_rdata),
        .m_data(a_data), .m_valid(a_valid), .m_ready(m_ready), .m_last(a_last)
`ifdef CAM_PIXCNT_EN
        , .pix_count(a_pix), .pix_count_valid(a_pixv)
`endif
    );

    cam_frame_reader #(.ADDR_W(ADDR_W), .NUM_WORDS(1), .FIFO_DEPTH(4)) dut_b (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .abort(abort),
        .busy(b_busy), .done(b_done), .cap_req(b_cap_req), .cap_ready(cap_ready),
        .ram_raddr(b_raddr), .ram_rdata(b_rdata),
        .m_data(b_data), .m_valid(b_valid), .m_ready(m_ready), .m_last(b_last)
`ifdef CAM_PIXCNT_EN
        , .pix_count(b_pix), .pix_count_valid(b_pixv)
`endif
    );

    // Capture RAM with its one-cycle read latency
    always @(posedge HCLK) begin
        a_rdata <= mem[a_raddr[2:0]];
        b_rdata <= mem[b_raddr[2:0]];
    end

    logic              cur_busy, cur_done, cur_cap_req, cur_valid, cur_last;
    logic [ADDR_W-1:0] cur_raddr;
    logic [31:0]       cur_data;
    assign cur_busy    = sel ? b_busy    : a_busy;
    assign cur_done    = sel ? b_done    : a_done;
    assign cur_cap_req = sel ? b_cap_req : a_cap_req;
    assign cur_valid   = sel ? b_valid   : a_valid;
    assign cur_last    = sel ? b_last    : a_last;
    assign cur_raddr   = sel ? b_raddr   : a_raddr;
    assign cur_data    = sel ? b_data    : a_data;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    // Monitor of the selected instance: accepted beats, done pulses, head stability under stall
    logic [31:0] got_data [$];
    logic        got_last [$];
    int          pop_cnt = 0;
    int          done_cnt = 0;
    int          stab_err = 0;
    int          first_pop_cyc = 0;
    int          last_pop_cyc = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    always @(negedge HCLK) begin
        if (mon_clear || HRESET) begin
            if (mon_clear) begin
                got_data.delete();
                got_last.delete();
                pop_cnt  = 0;
                done_cnt = 0;
                stab_err = 0;
            end
            prev_stall = 1'b0;
        end else begin
            if (cur_valid && m_ready) begin
                got_data.push_back(cur_data);
                got_last.push_back(cur_last);
                if (pop_cnt == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                pop_cnt++;
            end
            if (cur_done) done_cnt++;
            if (prev_stall && (cur_valid !== 1'b1 || cur_data !== prev_data || cur_last !== prev_last))
                stab_err++;
            prev_stall = cur_valid && !m_ready;
            prev_data  = cur_data;
            prev_last  = cur_last;
        end
    end

    // Consumer ready generator, with an optional 10-cycle stall once two beats were taken
    int          stall_left = 0;
    logic        stall_used = 1'b0;
    logic        stall_snap = 1'b0;
    logic [ADDR_W-1:0] stall_raddr_a = '0;
    logic [ADDR_W-1:0] stall_raddr_b = '0;
    int          stall_pops = 0;

    always @(posedge HCLK) begin
        #2;
        if (!stall_req) stall_used = 1'b0;
        else if (!stall_used && pop_cnt == 2) begin
            stall_used = 1'b1;
            stall_left = 10;
        end
        if (stall_left > 0) begin
            m_ready = 1'b0;
            if (stall_left == 3) stall_raddr_a = cur_raddr;
            stall_left--;
            if (stall_left == 0) stall_snap = 1'b1;
        end else begin
            if (stall_snap) begin
                stall_raddr_b = cur_raddr;
                stall_pops    = pop_cnt;
                stall_snap    = 1'b0;
            end
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic clear_monitor;
        mon_clear = 1'b1;
        tick;
        mon_clear = 1'b0;
    endtask

    task automatic wait_all_idle(output bit timeout);
        int n = 0;
        while ((a_busy !== 1'b0 || b_busy !== 1'b0) && n < 500) begin
            tick;
            n++;
        end
        timeout = (n >= 500);
        tick;
        tick;
    endtask

    // Drives one whole frame handshake; checks are left to the calling test
    task automatic run_frame(input bit extra_start, input bit rel_abort,
                             output logic req_seen, output bit timeout);
        int n;
        bit to2;
        start = 1'b1;
        tick;
        start = 1'b0;
        req_seen = cur_cap_req;
        repeat (4) tick;
        cap_ready = 1'b1;
        n = 0;
        while (cur_cap_req === 1'b1 && n < 500) begin
            start = extra_start && (n == 3);
            tick;
            n++;
        end
        start = 1'b0;
        timeout = (n >= 500);
        if (rel_abort) begin
            abort = 1'b1;
            tick;
            abort = 1'b0;
        end
        cap_ready = 1'b0;
        wait_all_idle(to2);
        timeout = timeout || to2;
    endtask

    task automatic test_reset;
        HRESET = 1'b1;
        repeat (3) tick;
        n_checks++;
        if ({a_busy, a_done, a_cap_req, a_valid, a_last} !== 5'b0) begin
            n_fails++;
            $display("[TB] FAIL reset_ctrl_a: got %b expected 00000", {a_busy, a_done, a_cap_req, a_valid, a_last});
        end
        n_checks++;
        if (a_raddr !== '0 || a_data !== 32'h0) begin
            n_fails++;
            $display("[TB] FAIL reset_addr_data_a: got raddr %0d data %h expected 0 / 0", a_raddr, a_data);
        end
        n_checks++;
        if ({b_busy, b_done, b_cap_req, b_valid, b_last} !== 5'b0 || b_data !== 32'h0) begin
            n_fails++;
            $display("[TB] FAIL reset_b: got ctrl %b data %h expected 00000 / 0",
                     {b_busy, b_done, b_cap_req, b_valid, b_last}, b_data);
        end
        HRESET = 1'b0;
        tick;
    endtask

    task automatic check_stream(input string name, input int n_words);
        n_checks++;
        if (pop_cnt != n_words) begin
            n_fails++;
            $display("[TB] FAIL %s_count: got %0d beats expected %0d", name, pop_cnt, n_words);
        end
        for (int i = 0; i < n_words; i++) begin
            n_checks++;
            if (i >= got_data.size() || got_data[i] !== mem[i] || got_last[i] !== (i == n_words - 1)) begin
                n_fails++;
                $display("[TB] FAIL %s_beat%0d: got %h last %b expected %h last %b", name, i,
                         (i < got_data.size()) ? got_data[i] : 32'hx,
                         (i < got_last.size()) ? got_last[i] : 1'bx, mem[i], (i == n_words - 1));
            end
        end
    endtask

    task automatic test_stream;
        logic req1;
        bit   to;
        for (int i = 0; i < 8; i++) mem[i] = 32'hA5000000 + i;
        sel = 1'b0;
        ready_mode = 0;
        clear_monitor;
        run_frame(1'b0, 1'b0, req1, to);
        n_checks++;
        if (to || req1 !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL stream_req: got cap_req %b timeout %0d expected 1 / 0", req1, to);
        end
        check_stream("stream", 8);
        n_checks++;
        if (last_pop_cyc - first_pop_cyc != 7) begin
            n_fails++;
            $display("[TB] FAIL stream_consecutive: got span %0d expected 7", last_pop_cyc - first_pop_cyc);
        end
        n_checks++;
        if (done_cnt != 1 || a_busy !== 1'b0 || a_done !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL stream_done: got %0d pulses busy %b done %b expected 1 / 0 / 0",
                     done_cnt, a_busy, a_done);
        end
    endtask

    task automatic test_backpressure;
        logic req1;
        bit   to;
        sel = 1'b0;
        ready_mode = 1;
        stall_req = 1'b1;
        clear_monitor;
        run_frame(1'b0, 1'b0, req1, to);
        stall_req = 1'b0;
        ready_mode = 0;
        n_checks++;
        if (to) begin
            n_fails++;
            $display("[TB] FAIL bp_timeout: got timeout 1 expected 0");
        end
        check_stream("bp", 8);
        n_checks++;
        if (stab_err != 0) begin
            n_fails++;
            $display("[TB] FAIL bp_stable: got %0d head changes under stall expected 0", stab_err);
        end
        n_checks++;
        if (stall_raddr_a !== stall_raddr_b || int'(stall_raddr_b) - stall_pops != 4) begin
            n_fails++;
            $display("[TB] FAIL bp_window: got raddr %0d->%0d with %0d pops expected frozen at pops+4",
                     stall_raddr_a, stall_raddr_b, stall_pops);
        end
        n_checks++;
        if (done_cnt != 1) begin
            n_fails++;
            $display("[TB] FAIL bp_done: got %0d pulses expected 1", done_cnt);
        end
    endtask

    task automatic test_abort;
        int   n;
        bit   to;
        logic req1;
        for (int i = 0; i < 8; i++) mem[i] = $urandom;
        sel = 1'b0;
        ready_mode = 0;
        clear_monitor;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        cap_ready = 1'b1;
        n = 0;
        while (pop_cnt < 2 && n < 200) begin
            tick;
            n++;
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        n_checks++;
        if (n >= 200 || cur_valid !== 1'b0 || cur_cap_req !== 1'b0 || cur_busy !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL abort_flush: got valid %b cap_req %b busy %b expected 0 / 0 / 1",
                     cur_valid, cur_cap_req, cur_busy);
        end
        repeat (3) tick;
        cap_ready = 1'b0;
        wait_all_idle(to);
        n_checks++;
        if (to || done_cnt != 0 || pop_cnt > 3) begin
            n_fails++;
            $display("[TB] FAIL abort_nodone: got %0d done %0d beats expected 0 done <=3 beats",
                     done_cnt, pop_cnt);
        end
        clear_monitor;
        run_frame(1'b0, 1'b0, req1, to);
        n_checks++;
        if (to || done_cnt != 1) begin
            n_fails++;
            $display("[TB] FAIL abort_restart_done: got %0d pulses expected 1", done_cnt);
        end
        check_stream("abort_restart", 8);
    endtask

    task automatic test_hreset;
        int   n;
        bit   to;
        logic req1;
        for (int i = 0; i < 8; i++) mem[i] = $urandom;
        sel = 1'b0;
        ready_mode = 0;
        clear_monitor;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        cap_ready = 1'b1;
        n = 0;
        while (pop_cnt < 3 && n < 200) begin
            tick;
            n++;
        end
        n_checks++;
        if (n >= 200 || a_cap_req !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL hreset_pre: got cap_req %b expected 1", a_cap_req);
        end
        HRESET = 1'b1;
        tick;
        n_checks++;
        if ({a_busy, a_done, a_cap_req, a_valid, a_last} !== 5'b0 || a_raddr !== '0 || a_data !== 32'h0) begin
            n_fails++;
            $display("[TB] FAIL hreset_outputs: got ctrl %b raddr %0d data %h expected 00000 / 0 / 0",
                     {a_busy, a_done, a_cap_req, a_valid, a_last}, a_raddr, a_data);
        end
        HRESET = 1'b0;
        cap_ready = 1'b0;
        repeat (3) tick;
        n_checks++;
        if (done_cnt != 0) begin
            n_fails++;
            $display("[TB] FAIL hreset_nodone: got %0d pulses expected 0", done_cnt);
        end
        sel = 1'b1;
        clear_monitor;
        run_frame(1'b0, 1'b0, req1, to);
        n_checks++;
        if (to || done_cnt != 1) begin
            n_fails++;
            $display("[TB] FAIL single_done: got %0d pulses timeout %0d expected 1 / 0", done_cnt, to);
        end
        check_stream("single", 1);
        sel = 1'b0;
    endtask

    task automatic test_ignored;
        logic req1;
        bit   to;
        for (int i = 0; i < 8; i++) mem[i] = $urandom;
        sel = 1'b0;
        ready_mode = 0;
        clear_monitor;
        run_frame(1'b1, 1'b1, req1, to);
        n_checks++;
        if (to || done_cnt != 1) begin
            n_fails++;
            $display("[TB] FAIL ignored_done: got %0d pulses expected 1", done_cnt);
        end
        check_stream("ignored", 8);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        n_checks++;
        if (a_busy !== 1'b0 || a_cap_req !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL idle_abort: got busy %b cap_req %b expected 0 / 0", a_busy, a_cap_req);
        end
    endtask

    task automatic test_back_to_back;
        logic req1;
        bit   to;
        sel = 1'b0;
        ready_mode = 2;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) mem[i] = $urandom;
            clear_monitor;
            run_frame(1'b0, 1'b0, req1, to);
            n_checks++;
            if (to || done_cnt != 1 || stab_err != 0) begin
                n_fails++;
                $display("[TB] FAIL b2b_frame%0d: got done %0d stall errors %0d expected 1 / 0",
                         f, done_cnt, stab_err);
            end
            check_stream("b2b", 8);
        end
        ready_mode = 0;
    endtask

`ifdef CAM_PIXCNT_EN
    task automatic test_pixcount;
        logic req1;
        bit   to;
        int   exp;
        sel = 1'b0;
        for (int f = 0; f < 2; f++) begin
            exp = 0;
            for (int i = 0; i < 8; i++) begin
                mem[i] = (f == 0) ? ((i % 2 == 0) ? 32'hFFFFFFFF : 32'h0) : $urandom;
                exp += $countones(mem[i]);
            end
            ready_mode = f * 2;
            clear_monitor;
            run_frame(1'b0, 1'b0, req1, to);
            n_checks++;
            if (to || int'(a_pix) != exp || a_pixv !== 1'b1) begin
                n_fails++;
                $display("[TB] FAIL pixcount%0d: got %0d valid %b expected %0d / 1", f, a_pix, a_pixv, exp);
            end
        end
        ready_mode = 0;
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        test_reset;
        test_stream;
        test_backpressure;
        test_abort;
        test_hreset;
        test_ignored;
        test_back_to_back;
`ifdef CAM_PIXCNT_EN
        test_pixcount;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
